// File: rtl/frame_color_shape_classifier_if.sv
// Pixel-stream / verdict bundle between the VGA scan side and the classifier.
interface frame_color_shape_classifier_if;
  logic [7:0] PIXEL_IN;
  logic [9:0] VGA_PIXEL_X;
  logic [9:0] VGA_PIXEL_Y;
  logic       VGA_VSYNC_NEG;
  logic [8:0] RESULT;
  logic       RESULT_VALID;

  modport master (
    output PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
    input  RESULT, RESULT_VALID
  );

  modport slave (
    input  PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
    output RESULT, RESULT_VALID
  );
endinterface

// File: rtl/frame_color_shape_classifier.sv
// Per-frame red/blue pixel counter and three-row width sampler; publishes a
// 9-bit colour/shape/size verdict on every vsync falling edge.
module frame_color_shape_classifier #(
  parameter int unsigned WIDTH    = 176,
  parameter int unsigned HEIGHT   = 144,
  parameter int unsigned COUNT_TH = 2000,
  parameter int unsigned BAND_TOP = 36,
  parameter int unsigned BAND_MID = 72,
  parameter int unsigned BAND_BOT = 108,
  parameter int unsigned TOL      = 8
) (
  input logic                          CLK,
  input logic                          RESET,
  frame_color_shape_classifier_if.slave bus
);

  localparam logic [9:0]  LP_W    = WIDTH[9:0];
  localparam logic [9:0]  LP_H    = HEIGHT[9:0];
  localparam logic [14:0] LP_TH   = COUNT_TH[14:0];
  localparam logic [9:0]  LP_ROW0 = BAND_TOP[9:0];
  localparam logic [9:0]  LP_ROW1 = BAND_MID[9:0];
  localparam logic [9:0]  LP_ROW2 = BAND_BOT[9:0];
  localparam logic [8:0]  LP_TOL  = TOL[8:0];

  logic [9:0]  r_x_d, r_y_d;
  logic        r_vs_d;
  logic [14:0] r_red_cnt, r_blue_cnt;
  logic [7:0]  r_red_w  [3];
  logic [7:0]  r_blue_w [3];
  logic [8:0]  r_result;
  logic        r_valid;

  logic        w_in_win, w_is_red, w_is_blue, w_frame_end;
  logic [2:0]  w_band_hit;
  logic [1:0]  w_colour, w_shape;
  logic [14:0] w_dom;
  logic [8:0]  w_t, w_m, w_b, w_d_tm, w_d_mb;
  logic [8:0]  w_verdict;

  assign bus.RESULT       = r_result;
  assign bus.RESULT_VALID = r_valid;

  // Pixel classification against the coordinates delayed to match M9K latency.
  always_comb begin
    w_in_win    = (r_x_d < LP_W) && (r_y_d < LP_H);
    w_is_red    = (bus.PIXEL_IN[7:5] >= 3'd5) && (bus.PIXEL_IN[1:0] <= 2'd1);
    w_is_blue   = (bus.PIXEL_IN[1:0] >= 2'd2) && (bus.PIXEL_IN[7:5] <= 3'd2);
    w_band_hit  = {r_y_d == LP_ROW2, r_y_d == LP_ROW1, r_y_d == LP_ROW0};
    w_frame_end = r_vs_d & ~bus.VGA_VSYNC_NEG;
  end

  // Frame verdict from the current accumulator contents (9-bit width maths).
  always_comb begin
    w_colour = '0;
    w_dom    = '0;
    w_t      = '0;
    w_m      = '0;
    w_b      = '0;
    if (r_red_cnt >= LP_TH && r_red_cnt > r_blue_cnt) begin
      w_colour = 2'b01;
      w_dom    = r_red_cnt;
      w_t      = {1'b0, r_red_w[0]};
      w_m      = {1'b0, r_red_w[1]};
      w_b      = {1'b0, r_red_w[2]};
    end else if (r_blue_cnt >= LP_TH && r_blue_cnt > r_red_cnt) begin
      w_colour = 2'b10;
      w_dom    = r_blue_cnt;
      w_t      = {1'b0, r_blue_w[0]};
      w_m      = {1'b0, r_blue_w[1]};
      w_b      = {1'b0, r_blue_w[2]};
    end
    w_d_tm  = (w_t > w_m) ? (w_t - w_m) : (w_m - w_t);
    w_d_mb  = (w_m > w_b) ? (w_m - w_b) : (w_b - w_m);
    w_shape = '0;
    if (w_colour != 2'b00) begin
      if (w_d_tm <= LP_TOL && w_d_mb <= LP_TOL && w_m != '0)
        w_shape = 2'b10;
      else if (w_t + LP_TOL < w_m && w_m + LP_TOL < w_b)
        w_shape = 2'b01;
      else if (w_t + LP_TOL < w_m && w_b + LP_TOL < w_m)
        w_shape = 2'b11;
    end
    // A 15-bit count shifted by 10 never exceeds 31, so the size is inherently saturated.
    w_verdict = {w_dom[14:10], w_shape, w_colour};
  end

  // Alignment stage for the M9K read latency and vsync edge history.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_x_d  <= '0;
      r_y_d  <= '0;
      r_vs_d <= 1'b1;
    end else begin
      r_x_d  <= bus.VGA_PIXEL_X;
      r_y_d  <= bus.VGA_PIXEL_Y;
      r_vs_d <= bus.VGA_VSYNC_NEG;
    end
  end

  // Saturating colour counts and band widths, cleared at every frame end.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_red_cnt  <= '0;
      r_blue_cnt <= '0;
      r_red_w    <= '{default: '0};
      r_blue_w   <= '{default: '0};
    end else if (w_frame_end) begin
      r_red_cnt  <= '0;
      r_blue_cnt <= '0;
      r_red_w    <= '{default: '0};
      r_blue_w   <= '{default: '0};
    end else if (w_in_win) begin
      if (w_is_red && r_red_cnt != '1)
        r_red_cnt <= r_red_cnt + 1'b1;
      if (w_is_blue && r_blue_cnt != '1)
        r_blue_cnt <= r_blue_cnt + 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_band_hit[i] && w_is_red && r_red_w[i] != '1)
          r_red_w[i] <= r_red_w[i] + 1'b1;
        if (w_band_hit[i] && w_is_blue && r_blue_w[i] != '1)
          r_blue_w[i] <= r_blue_w[i] + 1'b1;
      end
    end
  end

  // Verdict register and one-cycle valid pulse on the vsync falling edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_frame_end;
      if (w_frame_end)
        r_result <= w_verdict;
    end
  end

endmodule

// File: tb/tb_frame_color_shape_classifier.sv
// Scoreboard bench for frame_color_shape_classifier: frames are built as
// pixel lists, expected verdicts are queued, a monitor pops on RESULT_VALID.
module tb_frame_color_shape_classifier;

  localparam int W = 176;
  localparam int H = 144;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] p;
  } px_t;

  logic clk = 1'b0;
  logic rst;

  frame_color_shape_classifier_if bus();

  frame_color_shape_classifier #(
    .WIDTH(176), .HEIGHT(144), .COUNT_TH(2000),
    .BAND_TOP(36), .BAND_MID(72), .BAND_BOT(108), .TOL(8)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  px_t        frame[$];
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference verdict computed directly from the pixel list.
  function automatic logic [8:0] model();
    int rows[3] = '{36, 72, 108};
    int red = 0, blue = 0;
    int rw[3] = '{0, 0, 0};
    int bw[3] = '{0, 0, 0};
    int col, dom, t, m, b, shape, size;
    foreach (frame[i]) begin
      int r, bl;
      bit isr, isb;
      if (frame[i].x < W && frame[i].y < H) begin
        r   = int'(frame[i].p) / 32;
        bl  = int'(frame[i].p) % 4;
        isr = (r >= 5) && (bl <= 1);
        isb = (bl >= 2) && (r <= 2);
        if (isr && red < 32767) red++;
        if (isb && blue < 32767) blue++;
        for (int k = 0; k < 3; k++) begin
          if (frame[i].y == rows[k]) begin
            if (isr && rw[k] < 255) rw[k]++;
            if (isb && bw[k] < 255) bw[k]++;
          end
        end
      end
    end
    col = 0; dom = 0; t = 0; m = 0; b = 0;
    if (red >= 2000 && red > blue) begin
      col = 1; dom = red; t = rw[0]; m = rw[1]; b = rw[2];
    end else if (blue >= 2000 && blue > red) begin
      col = 2; dom = blue; t = bw[0]; m = bw[1]; b = bw[2];
    end
    shape = 0;
    if (col != 0) begin
      if ((t - m <= 8) && (m - t <= 8) && (m - b <= 8) && (b - m <= 8) && m > 0) shape = 2;
      else if (t + 8 < m && m + 8 < b) shape = 1;
      else if (t + 8 < m && b + 8 < m) shape = 3;
    end
    size = (dom / 1024 > 31) ? 31 : dom / 1024;
    return 9'(size * 16 + shape * 4 + col);
  endfunction

  // Raster fill of n pixels of value p starting at linear window index start.
  task automatic add_fill(input int start, input int n, input logic [7:0] p);
    for (int i = start; i < start + n; i++)
      frame.push_back('{x: i % W, y: i / W, p: p});
  endtask

  task automatic add_row(input int y, input int n, input logic [7:0] p);
    for (int x = 0; x < n; x++)
      frame.push_back('{x: x, y: y, p: p});
  endtask

  // Present coordinates, then the pixel one cycle later as the M9K would.
  task automatic play();
    logic [7:0] prev = 8'($urandom);
    foreach (frame[i]) begin
      bus.VGA_PIXEL_X = 10'(frame[i].x);
      bus.VGA_PIXEL_Y = 10'(frame[i].y);
      bus.PIXEL_IN    = prev;
      prev            = frame[i].p;
      @(posedge clk); #1;
    end
    bus.VGA_PIXEL_X = 10'd700;
    bus.VGA_PIXEL_Y = 10'd500;
    bus.PIXEL_IN    = prev;
    @(posedge clk); #1;
    bus.PIXEL_IN = 8'hE0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic end_frame(input logic [8:0] exp);
    check("result_hold", bus.RESULT, last_exp);
    exp_q.push_back(exp);
    last_exp = exp;
    frame.delete();
    bus.VGA_VSYNC_NEG = 1'b0;
    @(negedge clk);
    check("valid_early", bus.RESULT_VALID, 1'b0);
    @(negedge clk);
    check("valid_latency", bus.RESULT_VALID, 1'b1);
    repeat (6) @(posedge clk); #1;
    bus.VGA_VSYNC_NEG = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  // Monitor: every valid pulse must match the oldest queued verdict.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.RESULT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_valid: got pulse with RESULT %0h, expected no pulse (t=%0t)",
                 bus.RESULT, $time);
      end else begin
        check("result", bus.RESULT, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.VGA_VSYNC_NEG = 1'b1;
    bus.VGA_PIXEL_X   = 10'd700;
    bus.VGA_PIXEL_Y   = 10'd500;
    bus.PIXEL_IN      = 8'h00;
    last_exp          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", bus.RESULT, 9'h000);
    check("reset_valid", bus.RESULT_VALID, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Empty frame.
    end_frame(9'h000);

    // Full red frame: square, size 24.
    add_fill(0, W * H, 8'hE0);
    play();
    end_frame(9'h189);

    // Blue triangle 40/80/120 plus 16 filled rows.
    add_fill(0, 16 * W, 8'h03);
    add_row(36, 40, 8'h03);
    add_row(72, 80, 8'h03);
    add_row(108, 120, 8'h03);
    play();
    end_frame(9'h026);
    @(negedge clk);
    check("triangle_low_nibble", bus.RESULT[3:0], 4'b0110);
    @(posedge clk); #1;

    // Sparse red: below threshold.
    add_fill(0, 1000, 8'hE0);
    add_fill(1000, 500, 8'h00);
    play();
    end_frame(9'h000);

    // Tie between red and blue.
    add_fill(0, 3000, 8'hE0);
    add_fill(3000, 3000, 8'h03);
    play();
    end_frame(9'h000);

    // Red pixels only outside the window.
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) frame.push_back('{x: 176 + (i % 400), y: i % 144, p: 8'hE0});
      else            frame.push_back('{x: i % 176, y: 144 + (i % 300), p: 8'hE0});
    end
    play();
    end_frame(9'h000);

    // Red diamond 20/100/30 plus 16 filled rows.
    add_fill(0, 16 * W, 8'hE0);
    add_row(36, 20, 8'hE0);
    add_row(72, 100, 8'hE0);
    add_row(108, 30, 8'hE0);
    play();
    end_frame(9'h02D);

    // Reset mid-frame drops partial counts and clears RESULT.
    add_fill(0, 3000, 8'h03);
    play();
    frame.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_result", bus.RESULT, 9'h000);
    check("midreset_valid", bus.RESULT_VALID, 1'b0);
    @(posedge clk); #1;
    rst      = 1'b0;
    last_exp = '0;
    @(posedge clk); #1;
    add_fill(0, 2500, 8'hE0);
    play();
    end_frame(9'h021);

    // Randomized frames checked against the reference model.
    for (int f = 0; f < 3; f++) begin
      int dom = $urandom_range(0, 2);
      for (int i = 0; i < 4200; i++) begin
        logic [7:0] p;
        if ($urandom_range(0, 99) < 60 && dom == 0)
          p = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 1))};
        else if ($urandom_range(0, 99) < 60 && dom == 1)
          p = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(2, 3))};
        else
          p = 8'($urandom);
        frame.push_back('{x: int'($urandom_range(0, 199)), y: int'($urandom_range(0, 159)), p: p});
      end
      play();
      end_frame(model());
    end

    repeat (4) @(posedge clk);
    check("pending_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_color_shape_classifier.md
# frame_color_shape_classifier

Downstream consumer of the camera frame buffer. It samples the RGB332 pixel stream read out of the dual-port M9K as the VGA driver scans the 176×144 capture window. Per frame it counts red- and blue-dominant pixels and measures object width on three fixed rows. At each VGA vertical-sync falling edge it publishes a 9-bit colour/shape/size verdict, which goes to the Arduino over GPIO.

## Interface
Parameters:
- `WIDTH`, 176: capture window width in pixels.
- `HEIGHT`, 144: capture window height in pixels.
- `COUNT_TH`, 2000: minimum dominant-colour pixel count for a colour verdict.
- `BAND_TOP`, 36: first width-sampling row.
- `BAND_MID`, 72: second width-sampling row.
- `BAND_BOT`, 108: third width-sampling row.
- `TOL`, 8: width tolerance in pixels for shape decisions.

Ports:
- `CLK` in 1: 25 MHz VGA pixel clock, the same clock as the M9K read port.
- `RESET` in 1: asynchronous, active-high reset.
- `PIXEL_IN` in 8: RGB332 pixel from the M9K, packed as R[7:5] G[4:2] B[1:0].
- `VGA_PIXEL_X` in 10: current VGA scan column, which is also the read address column.
- `VGA_PIXEL_Y` in 10: current VGA scan row.
- `VGA_VSYNC_NEG` in 1: active-low vertical sync.
- `RESULT` out 9: [1:0] colour (00 none, 01 red, 10 blue); [3:2] shape (00 none, 01 triangle, 10 square, 11 diamond); [8:4] dominant count >> 10.
- `RESULT_VALID` out 1: one-cycle pulse when `RESULT` updates.

## Operation
Alignment stage:
- The M9K read has one cycle of latency, so X/Y are registered once. `PIXEL_IN` at edge k belongs to the X/Y sampled at edge k-1.
- A pixel is in-window when the delayed X < `WIDTH` and the delayed Y < `HEIGHT`. Out-of-window pixels are ignored.

Pixel classification (combinational, on `PIXEL_IN`):
- Red pixel: R ≥ 5 and B ≤ 1.
- Blue pixel: B ≥ 2 and R ≤ 2.
- Any other pixel counts as neither.

Accumulators, all cleared at frame end:
- `red_cnt` and `blue_cnt`, 15 bits each; the maximum 25344 fits.
- Six 8-bit band widths: red and blue on each of `BAND_TOP`, `BAND_MID` and `BAND_BOT`. A band width increments per classified in-window pixel whose delayed Y equals that band row.
- All counters saturate and never wrap.

Frame end: a falling edge of `VGA_VSYNC_NEG` is detected as `vs_d` = 1 and `VGA_VSYNC_NEG` = 0. At that edge the block does the following:

- Colour:
  - 01 if `red_cnt` ≥ `COUNT_TH` and `red_cnt` > `blue_cnt`.
  - 10 if `blue_cnt` ≥ `COUNT_TH` and `blue_cnt` > `red_cnt`.
  - Otherwise 00; this includes ties.
- Widths t, m, b: taken from the dominant colour's band counters.
- Shape (all comparisons done at 9 bits, no underflow):
  - Colour 00 gives shape 00.
  - Square (10): |t-m| ≤ `TOL`, |m-b| ≤ `TOL`, and m > 0.
  - Triangle (01): t+`TOL` < m and m+`TOL` < b.
  - Diamond (11): t+`TOL` < m and b+`TOL` < m.
  - Otherwise 00.
  - Square is checked first.
- Size field: dominant count >> 10, saturated at 31; 0 if colour is 00.
- `RESULT` is registered, `RESULT_VALID` is pulsed, and all accumulators are cleared, all on the same edge.
- The pixel in the alignment stage at that edge is discarded; it is always out-of-window during vsync.

Reset:
- `RESULT` = 0, `RESULT_VALID` = 0, all accumulators = 0, `vs_d` = 1, alignment registers = 0.
- Reset asserted mid-frame drops partial counts. The next verdict reflects only pixels seen after reset deassertion.

## Timing
- Pixel-to-accumulator latency: two edges after X/Y are presented (one for the M9K, one for the alignment stage).
- Verdict latency: `RESULT` and `RESULT_VALID` are visible one cycle after `VGA_VSYNC_NEG` is first sampled low.
- `RESULT` holds until the next frame end.
- `RESULT_VALID` is high for exactly one cycle per vsync falling edge. The vsync low interval produces no repeat pulse.
- The first frame after reset yields a verdict based on a partial frame if reset was released mid-frame.
- `RESULT` is never cleared between frames except by reset.

## Test plan
- Reset:
  - Assert `RESET` with `VGA_VSYNC_NEG` = 1 → `RESULT` = 0 and `RESULT_VALID` = 0.
  - Drop vsync with an empty frame → `RESULT` = 0 and one valid pulse.
- Full red frame: all in-window pixels 8'hE0 → `RESULT` = 9'h189 (colour 01, square, size 24), with one pulse one cycle after vsync falls.
- Blue triangle: blue 8'h03 widths 40/80/120 on rows 36/72/108 and total blue count ≥ 2000 → `RESULT`[3:0] = 4'b0110.
- Sparse red: 1000 red pixels, rest black → `RESULT` = 0.
- Tie: 3000 red and 3000 blue pixels → colour 00, `RESULT` = 0.
- Window, saturation and reset:
  - Red pixels only at X ≥ 176 or Y ≥ 144 → `RESULT` = 0.
  - Assert `RESET` mid-frame, then 2500 red pixels after release → colour 01, size 2.
